// File: rtl/dot_defs.sv
// Shared widths and FSM encodings for the dot-matrix frame path.
package dot_defs;

    localparam int ROW_W   = 8;
    localparam int NROW    = 8;
    localparam int FRAME_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/dot_rotl8.sv
// Rotates one display row left by a 3-bit column amount.
module dot_rotl8 (
    input  logic [7:0] d,
    input  logic [2:0] amt,
    output logic [7:0] y
);

    logic [15:0] dbl;

    // Upper byte of the doubled word shifted left is the wrap-around rotation.
    assign dbl = {d, d} << amt;
    assign y   = dbl[15:8];

endmodule

// File: rtl/dot_frame_ctrl.sv
// Double-buffered 8x8 frame controller: swaps only on frame ticks,
// optional horizontal scroll, registered frame to dot_decoder.
module dot_frame_ctrl
    import dot_defs::*;
#(
    parameter int FRAME_DIV  = 8,
    parameter int SCROLL_DIV = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [2:0]         waddr,
    input  logic [ROW_W-1:0]   wdata,
    output logic               wr_ready,
    input  logic               swap_req,
    input  logic               scroll_en,
    output logic               swap_done,
    output logic               frame_tick,
    output logic [FRAME_W-1:0] q
);

    localparam logic [7:0] FD_LAST = 8'(FRAME_DIV - 1);
    localparam logic [7:0] SD_LAST = 8'(SCROLL_DIV - 1);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       fcnt;
    logic [7:0]       scnt;
    logic [7:0]       scnt_nxt;
    logic [2:0]       offset;
    logic [2:0]       offset_nxt;
    logic             sel;
    logic             sel_nxt;
    logic             do_swap;
    logic             do_step;
    logic             do_count;
    logic             scroll_tick;
    logic [ROW_W-1:0] buf_a [NROW];
    logic [ROW_W-1:0] buf_b [NROW];
    logic [FRAME_W-1:0] rot_frame;

    assign frame_tick = (fcnt == FD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (swap_req) state_nxt = PENDING;
            PENDING: if (frame_tick) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_ready  = (state == IDLE);
        swap_done = (state == DONE);
        do_swap   = (state == PENDING) && frame_tick;
    end

    // A swap on the same tick overrides any scroll step.
    assign scroll_tick = frame_tick & scroll_en & ~do_swap;
    assign do_step     = scroll_tick & (scnt == SD_LAST);
    assign do_count    = scroll_tick & (scnt != SD_LAST);

    always_comb begin
        sel_nxt    = sel;
        offset_nxt = offset;
        scnt_nxt   = scnt;
        unique case (1'b1)
            do_swap: begin
                sel_nxt    = ~sel;
                offset_nxt = 3'd0;
                scnt_nxt   = 8'd0;
            end
            do_step: begin
                offset_nxt = offset + 3'd1;
                scnt_nxt   = 8'd0;
            end
            do_count: begin
                scnt_nxt = scnt + 8'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt   <= 8'd0;
            scnt   <= 8'd0;
            offset <= 3'd0;
            sel    <= 1'b0;
        end else begin
            fcnt   <= frame_tick ? 8'd0 : fcnt + 8'd1;
            scnt   <= scnt_nxt;
            offset <= offset_nxt;
            sel    <= sel_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NROW; i++) begin
                buf_a[i] <= '0;
                buf_b[i] <= '0;
            end
        end else if (we && wr_ready) begin
            if (sel) begin
                buf_a[waddr] <= wdata;
            end else begin
                buf_b[waddr] <= wdata;
            end
        end
    end

    // Rows are taken from the post-update front buffer and offset.
    for (genvar r = 0; r < NROW; r++) begin : g_row
        logic [ROW_W-1:0] src;
        assign src = sel_nxt ? buf_b[r] : buf_a[r];
        dot_rotl8 u_rot (
            .d   (src),
            .amt (offset_nxt),
            .y   (rot_frame[ROW_W*r +: ROW_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (frame_tick) begin
            q <= rot_frame;
        end
    end

endmodule

// File: tb/tb_dot_frame_ctrl.sv
// Bench for dot_frame_ctrl: two parameterisations against a frame-level model.
module tb_dot_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [2:0]  waddr;
    logic [7:0]  wdata;
    logic        swap_req;
    logic        scroll_en;

    logic        wr_ready0, swap_done0, frame_tick0;
    logic [63:0] q0;
    logic        wr_ready1, swap_done1, frame_tick1;
    logic [63:0] q1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dot_frame_ctrl #(.FRAME_DIV(8), .SCROLL_DIV(3)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .wr_ready   (wr_ready0),
        .swap_req   (swap_req),
        .scroll_en  (scroll_en),
        .swap_done  (swap_done0),
        .frame_tick (frame_tick0),
        .q          (q0)
    );

    dot_frame_ctrl #(.FRAME_DIV(2), .SCROLL_DIV(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .wr_ready   (wr_ready1),
        .swap_req   (swap_req),
        .scroll_en  (scroll_en),
        .swap_done  (swap_done1),
        .frame_tick (frame_tick1),
        .q          (q1)
    );

    // Model: front/back are whole frames exchanged on a swap;
    // pos is the scroll position in columns.
    typedef struct {
        int               fd;
        int               sd;
        int               cyc;
        int               phase;
        int               pos;
        int               sc;
        logic [7:0][7:0]  front;
        logic [7:0][7:0]  back;
        logic [63:0]      q;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mreset(int fd, int sd);
        mdl_t m;
        m.fd = fd;
        m.sd = sd;
        m.cyc = 0;
        m.phase = 0;
        m.pos = 0;
        m.sc = 0;
        m.front = '0;
        m.back = '0;
        m.q = '0;
        return m;
    endfunction

    function automatic logic [7:0] rot(logic [7:0] x, int p);
        int v;
        v = int'(x) << p;
        return 8'((v | (v >> 8)) & 255);
    endfunction

    function automatic logic m_tick(mdl_t m);
        return (m.cyc % m.fd) == (m.fd - 1);
    endfunction

    function automatic mdl_t mstep(mdl_t m, logic w, logic [2:0] a,
                                   logic [7:0] d, logic sr, logic se);
        logic tick;
        logic [7:0][7:0] t;
        tick = m_tick(m);
        if (m.phase == 0 && w) m.back[a] = d;
        if (m.phase == 1 && tick) begin
            t = m.front;
            m.front = m.back;
            m.back = t;
            m.pos = 0;
            m.sc = 0;
        end else if (tick && se) begin
            m.sc++;
            if (m.sc == m.sd) begin
                m.sc = 0;
                m.pos = (m.pos + 1) % 8;
            end
        end
        if (tick) begin
            for (int r = 0; r < 8; r++) m.q[8*r +: 8] = rot(m.front[r], m.pos);
        end
        case (m.phase)
            0: if (sr) m.phase = 1;
            1: if (tick) m.phase = 2;
            default: m.phase = 0;
        endcase
        m.cyc++;
        return m;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("ready0", 64'(wr_ready0), 64'(m0.phase == 0));
        chk("done0", 64'(swap_done0), 64'(m0.phase == 2));
        chk("tick0", 64'(frame_tick0), 64'(m_tick(m0)));
        chk("q0", q0, m0.q);
        chk("ready1", 64'(wr_ready1), 64'(m1.phase == 0));
        chk("done1", 64'(swap_done1), 64'(m1.phase == 2));
        chk("tick1", 64'(frame_tick1), 64'(m_tick(m1)));
        chk("q1", q1, m1.q);
    endtask

    task automatic step(logic w, logic [2:0] a, logic [7:0] d,
                        logic sr, logic se);
        we = w;
        waddr = a;
        wdata = d;
        swap_req = sr;
        scroll_en = se;
        #1;
        compare_all();
        m0 = mstep(m0, w, a, d, sr, se);
        m1 = mstep(m1, w, a, d, sr, se);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_vals(string tag);
        chk({tag, "_q0"}, q0, 64'h0);
        chk({tag, "_rdy0"}, 64'(wr_ready0), 64'h1);
        chk({tag, "_done0"}, 64'(swap_done0), 64'h0);
        chk({tag, "_tick0"}, 64'(frame_tick0), 64'h0);
        chk({tag, "_q1"}, q1, 64'h0);
        chk({tag, "_rdy1"}, 64'(wr_ready1), 64'h1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        we = 1'b0;
        waddr = '0;
        wdata = '0;
        swap_req = 1'b0;
        scroll_en = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        reset_vals("rst");
        rst_n = 1'b1;
        m0 = mreset(8, 3);
        m1 = mreset(2, 1);
    endtask

    initial begin
        do_reset();

        repeat (24) step(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) step(1'b1, 3'(r), 8'(1 << r), 1'b0, 1'b0);
        step(1'b0, 3'd0, 8'd0, 1'b1, 1'b0);
        repeat (7) step(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
        #1;
        chk("swap_q0", q0, 64'h8040201008040201);
        chk("swap_done0", 64'(swap_done0), 64'h1);
        chk("swap_q1", q1, 64'h8040201008040201);

        repeat (7) step(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 8'd0, 1'b1, 1'b0);
        step(1'b1, 3'd0, 8'hFF, 1'b0, 1'b0);
        repeat (16) step(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);

        repeat (120) step(1'b0, 3'd0, 8'd0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 8'd0, 1'b1, 1'b1);
        repeat (30) step(1'b0, 3'd0, 8'd0, 1'b0, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 11) == 0),
                 1'(((i / 200) % 3) != 0));
        end

        repeat (20) step(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
        for (int r = 0; r < 8; r++) step(1'b1, 3'(r), 8'($urandom_range(1, 255)), 1'b0, 1'b0);
        step(1'b0, 3'd0, 8'd0, 1'b1, 1'b0);
        repeat (20) step(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 8'd0, 1'b1, 1'b0);
        step(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        reset_vals("async");
        do_reset();
        repeat (40) step(1'b0, 3'd0, 8'd0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 8'd0, 1'b1, 1'b0);
        repeat (20) step(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
